// File: rtl/overlay_sched_if.sv
// Producer-side bundle of the overlay update scheduler: three req/ack channels
// (result engine, timer, UI) with the data each one posts.
interface overlay_sched_if;
  logic        res_req;
  logic [31:0] res_rez1;
  logic [31:0] res_rez2;
  logic        res_ack;
  logic        tim_req;
  logic [15:0] tim_freq;
  logic [15:0] tim_elapsed;
  logic        tim_ack;
  logic        ui_req;
  logic [7:0]  ui_mark;
  logic [5:0]  ui_bg;
  logic        ui_ack;

  // Handshake: a producer raises req with data stable and holds both until it
  // sees a one-cycle ack; data is captured on the edge that raises ack. The
  // producer may drop req the cycle after ack or keep it high to post again.
  modport master (
    output res_req, res_rez1, res_rez2, tim_req, tim_freq, tim_elapsed,
           ui_req, ui_mark, ui_bg,
    input  res_ack, tim_ack, ui_ack
  );

  modport slave (
    input  res_req, res_rez1, res_rez2, tim_req, tim_freq, tim_elapsed,
           ui_req, ui_mark, ui_bg,
    output res_ack, tim_ack, ui_ack
  );
endinterface

// File: rtl/overlay_sched.sv
// Frame-synchronous scheduler: round-robin arbitration of three display-value
// producers, committing into the display bank only while vsync is high.
module overlay_sched #(
  parameter int MAX_GRANTS = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vs,
  overlay_sched_if.slave prod,
  output logic [31:0]    rez1,
  output logic [31:0]    rez2,
  output logic [15:0]    freq,
  output logic [15:0]    elapsed,
  output logic [7:0]     mark,
  output logic [5:0]     bg,
  output logic [15:0]    frame_cnt,
  output logic           in_window,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MAX_G = 2'(MAX_GRANTS);

  state_e      state_q, state_d;
  logic        vs_d_q, vs_d_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [2:0]  served_q, served_d;
  logic [1:0]  grant_cnt_q, grant_cnt_d;
  logic [2:0]  ack_q, ack_d;
  logic [31:0] rez1_q, rez1_d, rez2_q, rez2_d;
  logic [15:0] freq_q, freq_d, elapsed_q, elapsed_d;
  logic [7:0]  mark_q, mark_d;
  logic [5:0]  bg_q, bg_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        in_window_q, in_window_d;

  logic [2:0]  req, eligible;
  logic [2:0]  cand3;
  logic [1:0]  gnt_idx;
  logic        found;
  logic        vs_rise;

  assign req     = {prod.ui_req, prod.tim_req, prod.res_req};
  assign vs_rise = vs & ~vs_d_q;

  // First eligible requester at or after ptr, scanning cyclically.
  always_comb begin
    eligible = req & ~served_q & ~ack_q;
    found    = 1'b0;
    gnt_idx  = 2'd0;
    cand3    = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand3 = {1'b0, ptr_q} + 3'(k);
      if (cand3 >= 3'd3) cand3 = cand3 - 3'd3;
      if (!found && eligible[cand3[1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand3[1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    vs_d_d      = vs;
    ptr_d       = ptr_q;
    served_d    = served_q;
    grant_cnt_d = grant_cnt_q;
    ack_d       = 3'b000;
    rez1_d      = rez1_q;
    rez2_d      = rez2_q;
    freq_d      = freq_q;
    elapsed_d   = elapsed_q;
    mark_d      = mark_q;
    bg_d        = bg_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (vs_rise) begin
          state_d     = SCAN;
          frame_cnt_d = frame_cnt_q + 16'd1;
          served_d    = 3'b000;
          grant_cnt_d = 2'd0;
        end
      end
      SCAN: begin
        if (!vs) begin
          state_d = IDLE;
        end else if (found && (grant_cnt_q < MAX_G)) begin
          ack_d[gnt_idx]    = 1'b1;
          served_d[gnt_idx] = 1'b1;
          grant_cnt_d       = grant_cnt_q + 2'd1;
          ptr_d             = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
          case (gnt_idx)
            2'd0: begin
              rez1_d = prod.res_rez1;
              rez2_d = prod.res_rez2;
            end
            2'd1: begin
              freq_d    = prod.tim_freq;
              elapsed_d = prod.tim_elapsed;
            end
            default: begin
              mark_d = prod.ui_mark;
              bg_d   = prod.ui_bg;
            end
          endcase
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!vs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_window_d = (state_d == SCAN);
  end

  // vs_d resets high so a reset released during vsync does not open a window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vs_d_q      <= 1'b1;
      ptr_q       <= 2'd0;
      served_q    <= 3'b000;
      grant_cnt_q <= 2'd0;
      ack_q       <= 3'b000;
      rez1_q      <= 32'd0;
      rez2_q      <= 32'd0;
      freq_q      <= 16'd0;
      elapsed_q   <= 16'd0;
      mark_q      <= 8'd0;
      bg_q        <= 6'd0;
      frame_cnt_q <= 16'd0;
      in_window_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_d_q      <= vs_d_d;
      ptr_q       <= ptr_d;
      served_q    <= served_d;
      grant_cnt_q <= grant_cnt_d;
      ack_q       <= ack_d;
      rez1_q      <= rez1_d;
      rez2_q      <= rez2_d;
      freq_q      <= freq_d;
      elapsed_q   <= elapsed_d;
      mark_q      <= mark_d;
      bg_q        <= bg_d;
      frame_cnt_q <= frame_cnt_d;
      in_window_q <= in_window_d;
    end
  end

  assign prod.res_ack = ack_q[0];
  assign prod.tim_ack = ack_q[1];
  assign prod.ui_ack  = ack_q[2];
  assign rez1         = rez1_q;
  assign rez2         = rez2_q;
  assign freq         = freq_q;
  assign elapsed      = elapsed_q;
  assign mark         = mark_q;
  assign bg           = bg_q;
  assign frame_cnt    = frame_cnt_q;
  assign in_window    = in_window_q;
  assign state_dbg    = state_q;

endmodule
